flop_fifo_flagged: RTL and testbench
====================================

// Module: flop_fifo_flagged
//
// PURPOSE
//   Parametrised successor to the flip-flop FIFO used between the bridge's APB
//   and AXI4-Lite sides.
//   Adds:
//   - a selectable read mode: first-word-fall-through or registered read.
//   - a live occupancy level.
//   - programmable almost-full and almost-empty flags.
//   - synchronous flush.
//   - sticky overflow/underflow error flags.
//   Sits on the command and response paths wherever back-pressure thresholds are needed.
//
// PARAMETERS
//   width   8   data bits per entry
//   depth   10  number of entries; any value >= 2, power of two not required
//   fwft    1   1 = head visible on read_data while !empty; 0 = read_data registered on pop
//   af_thr  8   almost_full asserted when level >= af_thr (range 1..depth)
//   ae_thr  1   almost_empty asserted when level <= ae_thr (range 0..depth-1)
//
// PORTS
//   clk           in   1                  clock, rising edge
//   rst           in   1                  asynchronous reset, active-high
//   flush         in   1                  synchronous clear of contents
//   push          in   1                  write request
//   write_data    in   width              data to write
//   pop           in   1                  read request
//   read_data     out  width              read data
//   read_valid    out  1                  read_data qualifier
//   empty         out  1                  level == 0
//   full          out  1                  level == depth
//   almost_empty  out  1                  level <= ae_thr
//   almost_full   out  1                  level >= af_thr
//   level         out  $clog2(depth+1)    current occupancy
//   overflow      out  1                  sticky: a push was dropped
//   underflow     out  1                  sticky: a pop was dropped
//   clear_err     in   1                  synchronous clear of overflow/underflow
//
// BEHAVIOUR
//   Reset (async assert):
//   - Pointers, level, read_data and read_valid go to 0; overflow and underflow go to 0.
//   - empty=1, full=0, almost_empty=1, almost_full=0.
//   - Reset mid-operation discards all contents.
//   Pointers:
//   - Pointers wrap from depth-1 to 0.
//   - Pointer width is $clog2(depth).
//   - Status flags decode from the registered level only (no combinational input paths).
//   Accept rules, evaluated each cycle:
//   - pop_ok  = pop & !empty
//   - push_ok = push & (!full | pop_ok)
//   - When full, push and pop in the same cycle are both accepted and level is unchanged.
//   - When empty, push and pop in the same cycle: push is accepted, pop is dropped and
//     underflow is set. This rule holds in both modes.
//   Level update:
//   - level += push_ok - pop_ok.
//   - level never exceeds depth and never wraps below 0.
//   Error flags:
//   - push & !push_ok sets overflow; pop & !pop_ok sets underflow.
//   - Both flags stay set until clear_err or rst.
//   - If clear_err and a new error occur in the same cycle, the flag is set.
//   flush:
//   - Zeroes the pointers and level next cycle; push and pop in that cycle are ignored.
//   - Does not count as an error; errors are retained.
//   - In fwft=0, read_valid goes to 0.
//   - Storage contents are not cleared.
//   fwft=1:
//   - read_data = data[rd_ptr], read_valid = !empty, both combinational from registers.
//   - A written word is visible the cycle after push.
//   - pop consumes the shown word.
//   fwft=0:
//   - On pop_ok, read_data <= data[rd_ptr] and read_valid <= 1 the next cycle
//     (1-cycle latency).
//   - read_valid is 0 otherwise.
//   - read_data holds its last value when no pop occurs.
//   Storage:
//   - Write to storage only on push_ok.
//   - Storage is not reset.
//
// TESTING (depth=5, width=8, af_thr=4, ae_thr=1)
//   1. Reset: with rst high, check empty=1, almost_empty=1, full=0, level=0,
//      overflow=0, underflow=0.
//   2. Fill and overfill: push 0x11..0x55 -> almost_full at level=4, full at level=5.
//      6th push 0x66 -> level stays 5 and overflow=1.
//      Drain -> 0x11..0x55 in order; 0x66 never appears.
//   3. Full push+pop: at level 5, one cycle of push 0xA0 with pop.
//      -> level stays 5, no overflow.
//      -> Popped order 0x11 first, 0xA0 last after 5 more pops.
//   4. Empty push+pop and fwft=0:
//      - At level 0, push 0x7E with pop -> underflow=1, level=1.
//      - Next pop -> read_valid=1 with read_data=0x7E one cycle later.
//      - Then clear_err -> underflow=0.
//   5. Flush: at level 3 with push asserted, pulse flush.
//      -> level=0 and empty=1 next cycle; sticky flags unchanged.
//      -> Following push 0x42 reads back as 0x42.
//   6. Wrap and async reset: run 23 pushes/pops with random gaps (> 4 wraps) and
//      compare against a queue model.
//      Assert rst between clock edges mid-stream -> outputs reach reset values
//      without waiting for a clk edge.

Source files
------------

// File: rtl/flop_fifo_flagged.sv
// Flip-flop FIFO with selectable FWFT/registered read, occupancy level,
// programmable almost-full/almost-empty thresholds, flush and sticky error flags.
module flop_fifo_flagged #(
   parameter int width  = 8,
   parameter int depth  = 10,
   parameter int fwft   = 1,
   parameter int af_thr = 8,
   parameter int ae_thr = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       push,
   input  logic [width-1:0]           write_data,
   input  logic                       pop,
   output logic [width-1:0]           read_data,
   output logic                       read_valid,
   output logic                       empty,
   output logic                       full,
   output logic                       almost_empty,
   output logic                       almost_full,
   output logic [$clog2(depth+1)-1:0] level,
   output logic                       overflow,
   output logic                       underflow,
   input  logic                       clear_err
);

   localparam int PW = (depth > 1) ? $clog2(depth) : 1;
   localparam int LW = $clog2(depth + 1);

   logic [width-1:0] mem [depth];
   logic [PW-1:0]    wr_ptr_reg;
   logic [PW-1:0]    rd_ptr_reg;
   logic [LW-1:0]    level_reg;
   logic             overflow_reg;
   logic             underflow_reg;
   logic             pop_acc;
   logic             push_acc;
   logic             pop_ok;
   logic             push_ok;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(depth - 1)) ? '0 : p + PW'(1);
   endfunction

   // Flags decode purely from the registered level.
   assign empty        = (level_reg == '0);
   assign full         = (level_reg == LW'(depth));
   assign almost_empty = (level_reg <= LW'(ae_thr));
   assign almost_full  = (level_reg >= LW'(af_thr));
   assign level        = level_reg;
   assign overflow     = overflow_reg;
   assign underflow    = underflow_reg;

   // A pop frees a slot, so a push into a full FIFO is accepted alongside it.
   assign pop_acc  = pop & ~empty;
   assign push_acc = push & (~full | pop_acc);
   assign pop_ok   = pop_acc & ~flush;
   assign push_ok  = push_acc & ~flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (push_ok)
            wr_ptr_reg <= next_ptr(wr_ptr_reg);
         if (pop_ok)
            rd_ptr_reg <= next_ptr(rd_ptr_reg);
         level_reg <= level_reg + LW'(push_ok) - LW'(pop_ok);
      end
   end

   // A fresh error in the same cycle as clear_err wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         overflow_reg  <= (overflow_reg & ~clear_err) | (push & ~push_acc & ~flush);
         underflow_reg <= (underflow_reg & ~clear_err) | (pop & ~pop_acc & ~flush);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr_reg] <= write_data;
   end

   generate
      if (fwft != 0) begin : g_fwft
         assign read_data  = mem[rd_ptr_reg];
         assign read_valid = ~empty;
      end else begin : g_reg
         logic [width-1:0] read_data_reg;
         logic             read_valid_reg;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               read_data_reg  <= '0;
               read_valid_reg <= 1'b0;
            end else begin
               read_valid_reg <= pop_ok;
               if (pop_ok)
                  read_data_reg <= mem[rd_ptr_reg];
            end
         end

         assign read_data  = read_data_reg;
         assign read_valid = read_valid_reg;
      end
   endgenerate

endmodule

// File: tb/tb_flop_fifo_flagged.sv
// Runs an FWFT instance and a registered-read instance side by side against a
// queue-based reference model, using directed scenarios and a random wrap run.
module tb_flop_fifo_flagged;

   localparam int W  = 8;
   localparam int D  = 5;
   localparam int AF = 4;
   localparam int AE = 1;
   localparam int LW = $clog2(D + 1);

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         flush = 1'b0;
   logic         push = 1'b0;
   logic [W-1:0] write_data = '0;
   logic         pop = 1'b0;
   logic         clear_err = 1'b0;

   logic [W-1:0]  f_rd, r_rd;
   logic          f_rv, r_rv, f_em, r_em, f_fu, r_fu, f_ae, r_ae, f_af, r_af;
   logic          f_ov, r_ov, f_un, r_un;
   logic [LW-1:0] f_lv, r_lv;

   always #5 clk = ~clk;

   flop_fifo_flagged #(.width(W), .depth(D), .fwft(1), .af_thr(AF), .ae_thr(AE)) u_fwft (
      .clk(clk), .rst(rst), .flush(flush), .push(push), .write_data(write_data),
      .pop(pop), .read_data(f_rd), .read_valid(f_rv), .empty(f_em), .full(f_fu),
      .almost_empty(f_ae), .almost_full(f_af), .level(f_lv), .overflow(f_ov),
      .underflow(f_un), .clear_err(clear_err));

   flop_fifo_flagged #(.width(W), .depth(D), .fwft(0), .af_thr(AF), .ae_thr(AE)) u_reg (
      .clk(clk), .rst(rst), .flush(flush), .push(push), .write_data(write_data),
      .pop(pop), .read_data(r_rd), .read_valid(r_rv), .empty(r_em), .full(r_fu),
      .almost_empty(r_ae), .almost_full(r_af), .level(r_lv), .overflow(r_ov),
      .underflow(r_un), .clear_err(clear_err));

   // reference model state
   logic [W-1:0] q[$];
   logic         m_ov, m_un, m_rv;
   logic [W-1:0] m_rd;
   int           vectors = 0;
   int           miscompares = 0;
   int           txn = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
      m_rv = 1'b0;
      m_rd = '0;
   endtask

   // One clock of the FIFO's rules applied to the queue.
   task automatic model_step();
      int  n;
      bit  pa, wa;
      n  = q.size();
      pa = pop && (n != 0);
      wa = push && ((n != D) || pa);
      if (clear_err) begin
         m_ov = 1'b0;
         m_un = 1'b0;
      end
      if (flush) begin
         q.delete();
         m_rv = 1'b0;
      end else begin
         if (push && !wa) m_ov = 1'b1;
         if (pop && !pa)  m_un = 1'b1;
         m_rv = pa;
         if (pa) m_rd = q.pop_front();
         if (wa) q.push_back(write_data);
      end
   endtask

   task automatic check_all();
      int n;
      n = q.size();
      check("f_level", 32'(f_lv), 32'(n));
      check("r_level", 32'(r_lv), 32'(n));
      check("f_empty", 32'(f_em), 32'(n == 0));
      check("r_empty", 32'(r_em), 32'(n == 0));
      check("f_full",  32'(f_fu), 32'(n == D));
      check("r_full",  32'(r_fu), 32'(n == D));
      check("f_aempty", 32'(f_ae), 32'(n <= AE));
      check("r_aempty", 32'(r_ae), 32'(n <= AE));
      check("f_afull", 32'(f_af), 32'(n >= AF));
      check("r_afull", 32'(r_af), 32'(n >= AF));
      check("f_ovf", 32'(f_ov), 32'(m_ov));
      check("r_ovf", 32'(r_ov), 32'(m_ov));
      check("f_unf", 32'(f_un), 32'(m_un));
      check("r_unf", 32'(r_un), 32'(m_un));
      check("f_rvalid", 32'(f_rv), 32'(n != 0));
      if (n != 0) check("f_rdata", 32'(f_rd), 32'(q[0]));
      check("r_rvalid", 32'(r_rv), 32'(m_rv));
      check("r_rdata", 32'(r_rd), 32'(m_rd));
   endtask

   // Drive one cycle of inputs, advance the model at the edge, check on the falling edge.
   task automatic cycle(input bit p, input logic [W-1:0] d, input bit o,
                        input bit f, input bit c);
      push = p; write_data = d; pop = o; flush = f; clear_err = c;
      @(posedge clk);
      model_step();
      @(negedge clk);
      txn++;
      $display("txn %0d push=%0b wd=%02h pop=%0b flush=%0b clr=%0b level=%0d",
               txn, p, d, o, f, c, q.size());
      check_all();
   endtask

   initial begin
      int pushes;
      int iters;
      model_reset();
      // 1. reset
      repeat (2) @(negedge clk);
      check_all();
      check("rst_f_rvalid", 32'(f_rv), 32'd0);
      check("rst_r_rdata", 32'(r_rd), 32'd0);
      rst = 1'b0;

      // 2. fill, overfill, drain
      for (int i = 1; i <= 5; i++) cycle(1, W'(8'h11 * i), 0, 0, 0);
      check("full_at_5", 32'(r_fu), 32'd1);
      cycle(1, 8'h66, 0, 0, 0);
      check("ovf_6th", 32'(r_ov), 32'd1);
      for (int i = 0; i < 5; i++) cycle(0, '0, 1, 0, 0);
      cycle(0, '0, 0, 0, 1);

      // 3. push+pop while full
      for (int i = 1; i <= 5; i++) cycle(1, W'(8'h11 * i), 0, 0, 0);
      cycle(1, 8'hA0, 1, 0, 0);
      check("fullpp_ovf", 32'(r_ov), 32'd0);
      check("fullpp_rdata", 32'(r_rd), 32'h11);
      for (int i = 0; i < 5; i++) cycle(0, '0, 1, 0, 0);
      check("fullpp_last", 32'(r_rd), 32'hA0);

      // 4. push+pop while empty
      cycle(1, 8'h7E, 1, 0, 0);
      check("emptypp_unf", 32'(r_un), 32'd1);
      cycle(0, '0, 1, 0, 0);
      check("reg_pop_7e", 32'(r_rd), 32'h7E);
      cycle(0, '0, 0, 0, 0);
      check("reg_rvalid_drop", 32'(r_rv), 32'd0);
      cycle(0, '0, 0, 0, 1);

      // 5. flush with push asserted, errors retained
      cycle(0, '0, 1, 0, 0);
      for (int i = 0; i < 3; i++) cycle(1, W'(8'hC0 + i), 0, 0, 0);
      cycle(1, 8'hEE, 0, 1, 0);
      check("flush_level", 32'(r_lv), 32'd0);
      check("flush_unf_kept", 32'(r_un), 32'd1);
      cycle(1, 8'h42, 0, 0, 0);
      cycle(0, '0, 1, 0, 0);
      check("flush_readback", 32'(r_rd), 32'h42);
      cycle(0, '0, 0, 0, 1);

      // 6. random wraps, then async reset between edges
      pushes = 0;
      iters = 0;
      while (pushes < 23 && iters < 400) begin
         bit p, o;
         p = ($urandom_range(0, 2) != 0);
         o = ($urandom_range(0, 2) == 0);
         if (p && (q.size() != D || o)) pushes++;
         cycle(p, W'($urandom), o, ($urandom_range(0, 40) == 0), ($urandom_range(0, 15) == 0));
         iters++;
      end
      check("wrap_pushes", 32'(pushes >= 23), 32'd1);
      for (int i = 0; i < 3; i++) cycle(1, W'($urandom), 0, 0, 0);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_all();
      check("async_rst_rvalid", 32'(r_rv), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 12; i++)
         cycle($urandom_range(0, 1) != 0, W'($urandom), $urandom_range(0, 1) != 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
